// File: rtl/vmem_wr_sched_if.sv
// Host-side pixel write port of the video-memory write scheduler (valid/ready handshake).
interface vmem_wr_sched_if;
    logic        host_valid;
    logic        host_ready;
    logic [9:0]  host_h;
    logic [8:0]  host_v;
    logic [23:0] host_data;

    modport master (output host_valid, host_h, host_v, host_data, input host_ready);
    modport slave  (input host_valid, host_h, host_v, host_data, output host_ready);
endinterface

// File: rtl/vmem_wr_sched.sv
// Buffers host pixel writes and commits them to video memory only during blanking.
// Optional front/back framebuffer swap on vsync is built when FB_SWAP_EN is defined.
module vmem_wr_sched #(
    parameter int DEPTH = 8,
    parameter int H_MAX = 640,
    parameter int V_MAX = 480,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    vmem_wr_sched_if.slave     host,
    input  logic               vga_valid,
    input  logic               vga_vsync,
    output logic               mem_we,
    output logic [9:0]         mem_h_addr,
    output logic [8:0]         mem_v_addr,
    output logic [23:0]        mem_wdata,
    output logic               mem_buf_sel,
    output logic [CW-1:0]      fifo_count,
    output logic               err_oob,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               front_sel
);

    typedef enum logic [1:0] {IDLE, DRAIN, SWAP_PEND} state_t;

    typedef struct packed {
        logic [9:0]  h;
        logic [8:0]  v;
        logic [23:0] data;
    } pix_t;

    localparam logic [9:0]    H_LIM  = 10'(H_MAX);
    localparam logic [8:0]    V_LIM  = 9'(V_MAX);
    localparam logic [CW-1:0] FULL_N = CW'(DEPTH);

    state_t        state, state_nxt;
    pix_t          fifo [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, in_range, accept, push, pop;
    logic          swap_start, swap_fire, ready_int;

    assign full       = (count == FULL_N);
    assign empty      = (count == '0);
    assign in_range   = (host.host_h < H_LIM) && (host.host_v < V_LIM);
    assign accept     = host.host_valid && ready_int;
    assign push       = accept && in_range;
    assign fifo_count = count;
    assign host.host_ready = ready_int;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (swap_start)                 state_nxt = SWAP_PEND;
                else if (!empty && !vga_valid)  state_nxt = DRAIN;
            end
            DRAIN: begin
                if (swap_start)                 state_nxt = SWAP_PEND;
                else if (empty || vga_valid)    state_nxt = IDLE;
            end
            SWAP_PEND: begin
                if (empty)                      state_nxt = IDLE;
            end
            default:                            state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // IDLE pops on the same edge it launches a drain, giving the two-edge write latency.
    always_comb begin
        pop       = 1'b0;
        swap_fire = 1'b0;
        ready_int = !full;
        case (state)
            IDLE, DRAIN: pop = !empty && !vga_valid;
            SWAP_PEND: begin
                pop       = !empty && !vga_valid;
                // host_ready is low here, so no push can race the swap
                swap_fire = empty;
                ready_int = 1'b0;
            end
            default: ;
        endcase
    end

    // ---------------- FIFO pointers and occupancy ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; flushing the pointers makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{h: host.host_h, v: host.host_v, data: host.host_data};
    end

    // ---------------- Write port and error flag ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_h_addr <= '0;
            mem_v_addr <= '0;
            mem_wdata  <= '0;
            err_oob    <= 1'b0;
        end else begin
            mem_we <= pop;
            if (pop) begin
                mem_h_addr <= fifo[rd_ptr].h;
                mem_v_addr <= fifo[rd_ptr].v;
                mem_wdata  <= fifo[rd_ptr].data;
            end
            if (accept && !in_range) err_oob <= 1'b1;
        end
    end

`ifdef FB_SWAP_EN
    logic vsync_q;

    // Falling vsync edge with a pending request parks the FSM until the queue drains.
    assign swap_start = vsync_q && !vga_vsync && swap_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            front_sel   <= 1'b0;
            swap_ack    <= 1'b0;
            mem_buf_sel <= 1'b0;
        end else begin
            vsync_q  <= vga_vsync;
            swap_ack <= swap_fire;
            if (swap_fire) front_sel   <= ~front_sel;
            if (pop)       mem_buf_sel <= ~front_sel;
        end
    end
`else
    logic unused_swap;

    assign swap_start  = 1'b0;
    assign swap_ack    = 1'b0;
    assign front_sel   = 1'b0;
    assign mem_buf_sel = 1'b0;
    assign unused_swap = ^{swap_req, vga_vsync, swap_fire};
`endif

endmodule
